// File: rtl/mmss_countdown_timer.sv
// Loadable MM:SS BCD countdown timer with pause/resume, a seconds-borrow pulse and a done pulse.
// Every output is registered; digits clamp on load and never count below 00:00.
module mmss_countdown_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic [2:0] ld_min_tens_i,
    input  logic [3:0] ld_min_units_i,
    input  logic [2:0] ld_sec_tens_i,
    input  logic [3:0] ld_sec_units_i,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_units_o,
    output logic [2:0] sec_tens_o,
    output logic [3:0] sec_units_o,
    output logic       sec_borrow_o,
    output logic       done_o,
    output logic       running_o,
    output logic       expired_o
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] min_tens_q, min_tens_d;
    logic [3:0] min_units_q, min_units_d;
    logic [2:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_units_q, sec_units_d;
    logic       sec_borrow_q, sec_borrow_d;
    logic       done_q, done_d;
    logic       running_q, expired_q;
    logic       count_zero;

    assign count_zero = (min_tens_q == 3'd0) && (min_units_q == 4'd0) &&
                        (sec_tens_q == 3'd0) && (sec_units_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        min_tens_d   = min_tens_q;
        min_units_d  = min_units_q;
        sec_tens_d   = sec_tens_q;
        sec_units_d  = sec_units_q;
        sec_borrow_d = 1'b0;

        if (load_i) begin
            min_tens_d  = (ld_min_tens_i  > 3'd5) ? 3'd5 : ld_min_tens_i;
            min_units_d = (ld_min_units_i > 4'd9) ? 4'd9 : ld_min_units_i;
            sec_tens_d  = (ld_sec_tens_i  > 3'd5) ? 3'd5 : ld_sec_tens_i;
            sec_units_d = (ld_sec_units_i > 4'd9) ? 4'd9 : ld_sec_units_i;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    if (start_i) begin
                        state_d = count_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pause_i) begin
                        state_d = PAUSED;
                    end else if (tick_i && !count_zero) begin
                        // Ripple the borrow digit by digit; minute tens is nonzero whenever it is reached
                        if (sec_units_q != 4'd0) begin
                            sec_units_d = sec_units_q - 4'd1;
                        end else begin
                            sec_units_d = 4'd9;
                            if (sec_tens_q != 3'd0) begin
                                sec_tens_d = sec_tens_q - 3'd1;
                            end else begin
                                sec_tens_d   = 3'd5;
                                sec_borrow_d = 1'b1;
                                if (min_units_q != 4'd0) begin
                                    min_units_d = min_units_q - 4'd1;
                                end else begin
                                    min_units_d = 4'd9;
                                    min_tens_d  = min_tens_q - 3'd1;
                                end
                            end
                        end
                        if ((min_tens_d == 3'd0) && (min_units_d == 4'd0) &&
                            (sec_tens_d == 3'd0) && (sec_units_d == 4'd0)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            min_tens_q   <= 3'd0;
            min_units_q  <= 4'd0;
            sec_tens_q   <= 3'd0;
            sec_units_q  <= 4'd0;
            sec_borrow_q <= 1'b0;
            done_q       <= 1'b0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_tens_q   <= min_tens_d;
            min_units_q  <= min_units_d;
            sec_tens_q   <= sec_tens_d;
            sec_units_q  <= sec_units_d;
            sec_borrow_q <= sec_borrow_d;
            done_q       <= done_d;
            running_q    <= (state_d == RUN);
            expired_q    <= (state_d == DONE);
        end
    end

    assign min_tens_o   = min_tens_q;
    assign min_units_o  = min_units_q;
    assign sec_tens_o   = sec_tens_q;
    assign sec_units_o  = sec_units_q;
    assign sec_borrow_o = sec_borrow_q;
    assign done_o       = done_q;
    assign running_o    = running_q;
    assign expired_o    = expired_q;

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Bench for mmss_countdown_timer: directed scenarios then random traffic, checked against
// a model that tracks the count as a plain number of seconds.
module tb_mmss_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, load, start, pause;
    logic [2:0] ldMinTens, ldSecTens;
    logic [3:0] ldMinUnits, ldSecUnits;
    logic [2:0] minTens, secTens;
    logic [3:0] minUnits, secUnits;
    logic       secBorrow, done, running, expired;

    int errors = 0;
    int checks = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int mTotal;
    int mState;
    bit mBorrow, mDone;

    mmss_countdown_timer dut (
        .clk           (clk),
        .reset         (reset),
        .tick_i        (tick),
        .load_i        (load),
        .start_i       (start),
        .pause_i       (pause),
        .ld_min_tens_i (ldMinTens),
        .ld_min_units_i(ldMinUnits),
        .ld_sec_tens_i (ldSecTens),
        .ld_sec_units_i(ldSecUnits),
        .min_tens_o    (minTens),
        .min_units_o   (minUnits),
        .sec_tens_o    (secTens),
        .sec_units_o   (secUnits),
        .sec_borrow_o  (secBorrow),
        .done_o        (done),
        .running_o     (running),
        .expired_o     (expired)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Reference model: count held as total seconds, state as a small integer
    task automatic modelReset();
        mTotal  = 0;
        mState  = M_IDLE;
        mBorrow = 0;
        mDone   = 0;
    endtask

    task automatic modelStep(input bit ld, input bit st, input bit pa, input bit tk,
                             input int mt, input int mu, input int stn, input int su);
        int prevState;
        prevState = mState;
        mBorrow   = 0;
        if (ld) begin
            if (mt > 5) mt = 5;
            if (mu > 9) mu = 9;
            if (stn > 5) stn = 5;
            if (su > 9) su = 9;
            mTotal = (mt * 10 + mu) * 60 + stn * 10 + su;
            mState = M_IDLE;
        end else if ((mState == M_IDLE || mState == M_PAUSED) && st) begin
            mState = (mTotal == 0) ? M_DONE : M_RUN;
        end else if (mState == M_RUN && pa) begin
            mState = M_PAUSED;
        end else if (mState == M_RUN && tk && mTotal > 0) begin
            if (mTotal % 60 == 0) mBorrow = 1;
            mTotal = mTotal - 1;
            if (mTotal == 0) mState = M_DONE;
        end
        mDone = (mState == M_DONE) && (prevState != M_DONE);
    endtask

    task automatic checkVal(input string tag, input string name, input logic [3:0] obs,
                            input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int minutes, seconds;
        minutes = mTotal / 60;
        seconds = mTotal % 60;
        checkVal(tag, "min_tens",   {1'b0, minTens},  4'(minutes / 10));
        checkVal(tag, "min_units",  minUnits,         4'(minutes % 10));
        checkVal(tag, "sec_tens",   {1'b0, secTens},  4'(seconds / 10));
        checkVal(tag, "sec_units",  secUnits,         4'(seconds % 10));
        checkVal(tag, "sec_borrow", {3'b0, secBorrow}, {3'b0, mBorrow});
        checkVal(tag, "done",       {3'b0, done},      {3'b0, mDone});
        checkVal(tag, "running",    {3'b0, running},   {3'b0, mState == M_RUN});
        checkVal(tag, "expired",    {3'b0, expired},   {3'b0, mState == M_DONE});
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it
    task automatic applyStimulus(input string tag, input bit ld, input bit st, input bit pa,
                                 input bit tk, input int mt = 0, input int mu = 0,
                                 input int stn = 0, input int su = 0);
        load       = ld;
        start      = st;
        pause      = pa;
        tick       = tk;
        ldMinTens  = 3'(mt);
        ldMinUnits = 4'(mu);
        ldSecTens  = 3'(stn);
        ldSecUnits = 4'(su);
        @(posedge clk);
        modelStep(ld, st, pa, tk, mt, mu, stn, su);
        #1;
        checkOutput(tag);
        load  = 0;
        start = 0;
        pause = 0;
        tick  = 0;
    endtask

    initial begin
        reset = 1;
        {tick, load, start, pause} = '0;
        {ldMinTens, ldMinUnits, ldSecTens, ldSecUnits} = '0;
        #1;
        modelReset();
        checkOutput("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        checkOutput("reset_release");

        $display("[TB] 01:00 single tick borrow");
        applyStimulus("ld0100", 1, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus("st0100", 0, 1, 0, 0);
        applyStimulus("tk0100", 0, 0, 0, 1);
        applyStimulus("after_borrow", 0, 0, 0, 0);

        $display("[TB] 00:02 countdown to done");
        applyStimulus("ld0002", 1, 0, 0, 1, 0, 0, 0, 2);
        applyStimulus("st0002", 0, 1, 0, 0);
        applyStimulus("tk1", 0, 0, 0, 1);
        applyStimulus("tk2", 0, 0, 0, 1);
        applyStimulus("tk_done", 0, 0, 0, 1);
        applyStimulus("st_in_done", 0, 1, 0, 1);

        $display("[TB] 10:00 pause and resume");
        applyStimulus("ld1000", 1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus("st1000", 0, 1, 0, 0);
        applyStimulus("tk1000", 0, 0, 0, 1);
        applyStimulus("pause_tick", 0, 0, 1, 1);
        applyStimulus("paused_tick", 0, 0, 0, 1);
        applyStimulus("resume", 0, 1, 1, 0);
        applyStimulus("tk_resumed", 0, 0, 0, 1);
        applyStimulus("start_pause_run", 0, 1, 1, 1);

        $display("[TB] clamped load");
        applyStimulus("ld_clamp", 1, 0, 0, 0, 7, 12, 6, 15);
        applyStimulus("st_clamp", 0, 1, 0, 0);
        applyStimulus("tk_clamp", 0, 0, 0, 1);
        applyStimulus("ld_over_run", 1, 1, 0, 1, 0, 0, 5, 9);

        $display("[TB] start at 00:00");
        applyStimulus("ld0000", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("st0000", 0, 1, 0, 0);
        applyStimulus("hold0000", 0, 0, 0, 1);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus("ld0530", 1, 0, 0, 0, 0, 5, 3, 0);
        applyStimulus("st0530", 0, 1, 0, 0);
        repeat (3) applyStimulus("tk0530", 0, 0, 0, 1);
        #2;
        reset = 1;
        #1;
        modelReset();
        checkOutput("async_reset");
        #2;
        reset = 0;
        applyStimulus("tick_after_reset", 0, 0, 0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            bit rl, rs, rp, rt;
            int mt, mu, stn, su;
            rl = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 7) == 0);
            rp = ($urandom_range(0, 11) == 0);
            rt = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                mt  = 0;
                mu  = $urandom_range(0, 1);
                stn = $urandom_range(0, 1);
                su  = $urandom_range(0, 15);
            end else begin
                mt  = $urandom_range(0, 7);
                mu  = $urandom_range(0, 15);
                stn = $urandom_range(0, 7);
                su  = $urandom_range(0, 15);
            end
            applyStimulus("random", rl, rs, rp, rt, mt, mu, stn, su);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
